// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial LSB-first a - b - bin over WIDTH cycles, start/done
//            handshake. Define ADD_MODE_EN for the optional sub/add select.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
`ifdef ADD_MODE_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_br_sub;

   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_cnt == c_LAST);
   assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
   assign w_br_sub = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);

`ifdef ADD_MODE_EN
   logic r_sub;
   logic w_cy_add;

   assign w_cy_add = (r_sa[0] & r_sb[0]) | (r_br & (r_sa[0] ^ r_sb[0]));
   assign w_br_nxt = r_sub ? w_br_sub : w_cy_add;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sub <= 1'b1;
      end else if (w_accept) begin
         r_sub <= sub;
      end
   end
`else
   assign w_br_nxt = w_br_sub;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_nxt = SHIFT;
         SHIFT:   if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operands, borrow and result share one register block so the start
   // capture and the per-bit shift can never both update them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else if (w_accept) begin
         r_sa   <= a;
         r_sb   <= b;
         r_br   <= bin;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else if (r_state == SHIFT) begin
         r_sa   <= {1'b0, r_sa[WIDTH-1:1]};
         r_sb   <= {1'b0, r_sb[WIDTH-1:1]};
         r_br   <= w_br_nxt;
         r_cnt  <= r_cnt + CW'(1);
         r_diff <= {w_d, r_diff[WIDTH-1:1]};
         if (w_last) begin
            r_bout <= w_br_nxt;
         end
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign diff = r_diff;
   assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
`ifdef ADD_MODE_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   int n_vec  = 0;
   int n_fail = 0;
   logic [WIDTH:0] exp_q[$];
   logic           prev_done = 1'b0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
`ifdef ADD_MODE_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         check("done_single_cycle", {31'd0, prev_done}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [WIDTH:0] e;
            e = exp_q.pop_front();
            check("diff", {24'd0, diff}, {24'd0, e[WIDTH:1]});
            check("bout", {31'd0, bout}, {31'd0, e[0]});
         end
      end
      prev_done = (done === 1'b1);
   end

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tbin, input logic [WIDTH-1:0] ed,
                         input logic eb, input bit poke);
      int got;
      int lat;
      got = 0;
      lat = 0;
      @(negedge clk);
      a = ta; b = tb_; bin = tbin; start = 1'b1;
      exp_q.push_back({ed, eb});
      @(posedge clk);
      #1;
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      for (int k = 1; k <= WIDTH + 6; k++) begin
         @(negedge clk);
         if (poke) begin
            a = '0; b = '1;
            start = (k == 3) || (done === 1'b1);
         end
         if (done === 1'b1) begin
            got++;
            if (lat == 0) lat = k;
         end
      end
      start = 1'b0;
      check("done_count", got, 1);
      check("latency", lat, WIDTH + 1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("held_diff", {24'd0, diff}, {24'd0, ed});
      check("held_bout", {31'd0, bout}, {31'd0, eb});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'b1;
`ifdef ADD_MODE_EN
      sub = 1'b1;
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outputs", {22'd0, busy, done, diff, bout}, 32'd0);
         a = WIDTH'($urandom); b = WIDTH'($urandom);
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_idle", {30'd0, busy, done}, 32'd0);
      end

      run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

      // Reset in the middle of a SHIFT: no result is expected.
      @(negedge clk);
      a = 8'hC3; b = 8'h3C; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("midreset_outputs", {22'd0, busy, done, diff, bout}, 32'd0);
      repeat (3) @(negedge clk);
      check("midreset_held", {22'd0, busy, done, diff, bout}, 32'd0);
      rst_n = 1'b1;
      repeat (WIDTH + 2) @(negedge clk);
      check("midreset_no_done", {31'd0, busy}, 32'd0);
      run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

`ifdef ADD_MODE_EN
      sub = 1'b0;
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
      sub = 1'b1;
      run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected $finish before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire
